cache_repl_policy: RTL

Parametrised cache replacement-policy unit for the L1 I$/D$: per set, it chooses the way to evict on a fill. It selects between tree pseudo-LRU and LFSR random at run time, and supports any power-of-2 way count from 2 to 128. Per-set PLRU state is cleared by a multi-cycle sweep instead of a single-cycle array clear. It sits beside the tag/valid arrays and drives the victim one-hot into the way write enables.

---
 rtl/cache_repl_policy.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cache_repl_policy.sv
// Per-set victim selection (tree pseudo-LRU or LFSR random) with a multi-cycle PLRU state sweep.
// Define CACHE_WAYLOCK_EN to add the LockWay mask that steers all-valid victims off locked ways.
module cache_repl_policy #(
  parameter int unsigned NUMWAYS   = 4,
  parameter int unsigned SETLEN    = 9,
  parameter int unsigned NUMLINES  = 128,
  parameter int unsigned LFSRWIDTH = $clog2(NUMWAYS) + 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                FlushStage,
  input  logic                CacheEn,
  input  logic                PolicySel,
  input  logic [NUMWAYS-1:0]  HitWay,
  input  logic [NUMWAYS-1:0]  ValidWay,
`ifdef CACHE_WAYLOCK_EN
  input  logic [NUMWAYS-1:0]  LockWay,
`endif
  input  logic [SETLEN-1:0]   CacheSetTag,
  input  logic [SETLEN-1:0]   PAdr,
  input  logic                LRUWriteEn,
  input  logic                SetValid,
  input  logic                InvalidateCache,
  output logic [NUMWAYS-1:0]  VictimWay,
  output logic                ReplBusy
);
  localparam int WayBits  = $clog2(NUMWAYS);
  localparam int TreeBits = int'(NUMWAYS) - 1;
  localparam logic [8:0] LfsrTaps = (LFSRWIDTH == 5) ? 9'h005 :
                                    (LFSRWIDTH == 8) ? 9'h01D :
                                    (LFSRWIDTH == 9) ? 9'h011 : 9'h003;

  typedef enum logic [0:0] {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [SETLEN-1:0]   ctr_q, ctr_d;
  logic                sweeping, start_inval, sweep_last;

  logic [TreeBits-1:0] lru_mem [NUMLINES];
  logic [TreeBits-1:0] curr_lru_q, new_lru, upd_mask, upd_val;
  logic [LFSRWIDTH-1:0] lfsr_q;
  logic                lfsr_fb;
  logic [WayBits-1:0]  plru_way, cand_way, final_cand, victim_enc, hit_enc, access_way;
  logic [WayBits-1:0]  first_invalid;
  logic                any_invalid, node_bit;
  int                  walk_g, node_idx;

  assign start_inval = InvalidateCache & ~FlushStage;
  assign sweep_last  = (ctr_q == SETLEN'(NUMLINES - 1));

  // Reset lands in the sweep so the state memory never needs a reset of its own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StSweep;
      ctr_q   <= '0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    case (state_q)
      StIdle: begin
        if (start_inval) begin
          state_d = StSweep;
          ctr_d   = '0;
        end
      end
      StSweep: begin
        if (start_inval)     ctr_d   = '0;
        else if (sweep_last) state_d = StIdle;
        else                 ctr_d   = ctr_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    sweeping = (state_q == StSweep);
    ReplBusy = sweeping;
  end

  always_ff @(posedge clk) begin
    if (sweeping)        lru_mem[ctr_q] <= '0;
    else if (LRUWriteEn) lru_mem[PAdr]  <= new_lru;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         curr_lru_q <= '0;
    else if (sweeping) curr_lru_q <= '0;
    else if (CacheEn)  curr_lru_q <= (LRUWriteEn && (PAdr == CacheSetTag)) ? new_lru
                                                                             : lru_mem[CacheSetTag];
  end

  assign lfsr_fb = ^(lfsr_q & LfsrTaps[LFSRWIDTH-1:0]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      lfsr_q <= LFSRWIDTH'(1);
    else if (LRUWriteEn & SetValid) lfsr_q <= {lfsr_fb, lfsr_q[LFSRWIDTH-1:1]};
  end

  // Tree nodes are stored level by level from the leaf pairs upward; level l starts at
  // NUMWAYS - NUMWAYS/2^l and the root is the last bit.
  always_comb begin
    plru_way = '0;
    walk_g   = 0;
    node_idx = 0;
    node_bit = 1'b0;
    for (int l = WayBits - 1; l >= 0; l--) begin
      node_idx = int'(NUMWAYS) - int'(NUMWAYS >> l) + walk_g;
      node_bit = |(curr_lru_q & (TreeBits'(1) << node_idx));
      plru_way = plru_way | (WayBits'(node_bit) << l);
      walk_g   = 2 * walk_g + int'(node_bit);
    end
  end

  always_comb begin
    hit_enc       = '0;
    first_invalid = '0;
    for (int i = 0; i < int'(NUMWAYS); i++) begin
      if (HitWay[i]) hit_enc = hit_enc | WayBits'(i);
    end
    for (int i = int'(NUMWAYS) - 1; i >= 0; i--) begin
      if (!ValidWay[i]) first_invalid = WayBits'(i);
    end
    any_invalid = ~&ValidWay;
  end

  assign cand_way = PolicySel ? lfsr_q[WayBits-1:0] : plru_way;

`ifdef CACHE_WAYLOCK_EN
  logic               lock_found;
  logic [WayBits-1:0] lock_probe;

  always_comb begin
    final_cand = cand_way;
    lock_found = 1'b0;
    lock_probe = cand_way;
    if (LockWay[cand_way] && !(&LockWay)) begin
      for (int i = 1; i < int'(NUMWAYS); i++) begin
        lock_probe = cand_way + WayBits'(i);
        if (!lock_found && !LockWay[lock_probe]) begin
          final_cand = lock_probe;
          lock_found = 1'b1;
        end
      end
    end
  end
`else
  assign final_cand = cand_way;
`endif

  assign victim_enc = any_invalid ? first_invalid : final_cand;
  assign VictimWay  = NUMWAYS'(1) << victim_enc;
  assign access_way = SetValid ? victim_enc : hit_enc;

  // Every node on the accessed way's path is turned to point away from it.
  always_comb begin
    upd_mask = '0;
    upd_val  = '0;
    for (int l = 0; l < WayBits; l++) begin
      upd_mask = upd_mask | (TreeBits'(1) << (int'(NUMWAYS) - int'(NUMWAYS >> l)
                                              + (int'(access_way) >> (l + 1))));
      if (!(|(access_way & (WayBits'(1) << l)))) begin
        upd_val = upd_val | (TreeBits'(1) << (int'(NUMWAYS) - int'(NUMWAYS >> l)
                                              + (int'(access_way) >> (l + 1))));
      end
    end
    new_lru = (curr_lru_q & ~upd_mask) | upd_val;
  end

endmodule
